// File: rtl/b16_dbg_pkg.sv
// Shared constants for the b16 debug controller: register map, breakpoint
// access modes and halt reason codes.
package b16_dbg_pkg;

  // Controller register indices (addr[3:1] when addr[4] is set)
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STEP   = 3'd1;
  localparam logic [2:0] REG_BPSEL  = 3'd2;
  localparam logic [2:0] REG_BPADDR = 3'd3;
  localparam logic [2:0] REG_BPCTL  = 3'd4;
  localparam logic [2:0] REG_HIT    = 3'd5;
  localparam logic [2:0] REG_CYCLE  = 3'd6;
  localparam logic [2:0] REG_RSVD   = 3'd7;

  // Breakpoint access-type modes (BPCTL[2:1])
  typedef enum logic [1:0] {
    BP_FETCH = 2'b00,
    BP_READ  = 2'b01,
    BP_WRITE = 2'b10,
    BP_ANY   = 2'b11
  } bp_mode_t;

  // Halt reason codes (CTRL read bits [L-1:L-4])
  typedef enum logic [3:0] {
    RSN_NONE = 4'd0,
    RSN_BP   = 4'd1,
    RSN_STEP = 4'd2,
    RSN_HOST = 4'd3
  } rsn_t;

endpackage

// File: rtl/b16_bp_match.sv
// One breakpoint channel: address/control registers plus the access-type
// comparator. 'active' carries drun & ~skip from the controller.
module b16_bp_match
  import b16_dbg_pkg::*;
#(
  parameter int unsigned L = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we_addr,
  input  logic         we_ctl,
  input  logic [L-1:0] wdata,
  input  logic [L-1:0] cpu_addr,
  input  logic         cpu_r,
  input  logic [1:0]   cpu_w,
  input  logic         cpu_fetch,
  input  logic         active,
  output logic [L-1:0] bpaddr,
  output logic [2:0]   bpctl,
  output logic         match
);

  logic mode_ok;

  // Channel registers, written by the host through the selected-BP window
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bpaddr <= '1;
      bpctl  <= '0;
    end else begin
      if (we_addr) bpaddr <= wdata;
      if (we_ctl)  bpctl  <= wdata[2:0];
    end
  end

  // Access-type qualification for the programmed mode
  always_comb begin
    mode_ok = 1'b0;
    case (bp_mode_t'(bpctl[2:1]))
      BP_FETCH: mode_ok = cpu_fetch & cpu_r;
      BP_READ:  mode_ok = cpu_r & ~cpu_fetch;
      BP_WRITE: mode_ok = |cpu_w;
      BP_ANY:   mode_ok = (cpu_fetch & cpu_r) | (cpu_r & ~cpu_fetch) | (|cpu_w);
    endcase
  end

  assign match = bpctl[0] & active & (cpu_addr == bpaddr) & mode_ok;

endmodule

// File: rtl/b16_debug_ctrl.sv
// b16 debug controller: decodes a 16-word window, forwards the lower half to
// the CPU debug port and implements breakpoints, stepping and halt control.
module b16_debug_ctrl
  import b16_dbg_pkg::*;
#(
  parameter int unsigned L       = 16,
  parameter int unsigned NBP     = 4,
  parameter logic [L-6:0] DBGADDR = 11'h7FF,
  parameter int unsigned CNTW    = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [L-1:0] addr,
  input  logic [L-1:0] data,
  input  logic         r,
  input  logic [1:0]   w,
  output logic [L-1:0] rdata,
  input  logic [L-1:0] cpu_addr,
  input  logic         cpu_r,
  input  logic [1:0]   cpu_w,
  input  logic         cpu_fetch,
  output logic         drun,
  output logic         dr,
  output logic         dw,
  output logic [2:0]   daddr,
  output logic         halted
);

  localparam int unsigned SELW = (NBP > 1) ? $clog2(NBP) : 1;

  logic            dsel, cpu_sel, reg_sel, host_wr, ctrl_wr;
  logic [2:0]      idx;
  logic            step_mode, skip, bp_hit, step_fetch, active;
  rsn_t            reason;
  logic [CNTW-1:0] step_q, cycle_q;
  logic [SELW-1:0] bpsel;
  logic [NBP-1:0]  hit, match_v, we_addr_v, we_ctl_v;
  logic [L-1:0]    bpaddr_a [NBP];
  logic [2:0]      bpctl_a  [NBP];
  logic            unused_addr0;

  assign dsel       = (addr[L-1:5] == DBGADDR);
  assign cpu_sel    = dsel & ~addr[4];
  assign reg_sel    = dsel & addr[4];
  assign idx        = addr[3:1];
  assign dr         = cpu_sel & r;
  assign dw         = cpu_sel & (|w);
  assign daddr      = addr[3:1];
  assign halted     = ~drun;
  assign host_wr    = reg_sel & (|w);
  assign ctrl_wr    = host_wr && (idx == REG_CTRL);
  assign active     = drun & ~skip;
  assign bp_hit     = |match_v;
  assign step_fetch = drun & step_mode & cpu_fetch;
  assign unused_addr0 = addr[0];

  for (genvar i = 0; i < NBP; i++) begin : g_bp
    assign we_addr_v[i] = host_wr && (idx == REG_BPADDR) && (bpsel == SELW'(i));
    assign we_ctl_v[i]  = host_wr && (idx == REG_BPCTL)  && (bpsel == SELW'(i));

    b16_bp_match #(.L(L)) u_bp (
      .clk      (clk),
      .reset    (reset),
      .we_addr  (we_addr_v[i]),
      .we_ctl   (we_ctl_v[i]),
      .wdata    (data),
      .cpu_addr (cpu_addr),
      .cpu_r    (cpu_r),
      .cpu_w    (cpu_w),
      .cpu_fetch(cpu_fetch),
      .active   (active),
      .bpaddr   (bpaddr_a[i]),
      .bpctl    (bpctl_a[i]),
      .match    (match_v[i])
    );
  end

  // Run/halt control, step counter, hit mask, selector and cycle counter.
  // Halt sources are prioritised host CTRL write > breakpoint > step; a
  // losing source leaves its side effects (HIT bits, STEP decrement) undone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drun      <= 1'b1;
      step_mode <= 1'b0;
      skip      <= 1'b0;
      reason    <= RSN_NONE;
      step_q    <= '0;
      bpsel     <= '0;
      hit       <= '0;
      cycle_q   <= '0;
    end else begin
      skip <= 1'b0;
      if (drun) cycle_q <= cycle_q + 1'b1;

      if (host_wr && (idx == REG_BPSEL)) bpsel <= SELW'(data % NBP);

      if (host_wr && (idx == REG_HIT)) hit <= (hit & ~data[NBP-1:0]) | match_v;
      else if (!ctrl_wr)               hit <= hit | match_v;

      if (host_wr && (idx == REG_STEP))
        step_q <= data[CNTW-1:0];
      else if (!ctrl_wr && !bp_hit && step_fetch && (step_q != '0))
        step_q <= step_q - 1'b1;

      if (ctrl_wr) begin
        drun      <= data[0];
        step_mode <= data[1];
        skip      <= data[0];
        if (!data[0])     reason <= RSN_HOST;
        else if (data[2]) reason <= RSN_NONE;
      end else if (bp_hit) begin
        drun   <= 1'b0;
        reason <= RSN_BP;
      end else if (step_fetch && (step_q <= CNTW'(1))) begin
        drun   <= 1'b0;
        reason <= RSN_STEP;
      end
    end
  end

  // Register read mux; zero outside the controller half of the window
  always_comb begin
    rdata = '0;
    if (reg_sel) begin
      case (idx)
        REG_CTRL: begin
          rdata[L-1:L-4] = reason;
          rdata[1]       = step_mode;
          rdata[0]       = drun;
        end
        REG_STEP:   rdata[CNTW-1:0] = step_q;
        REG_BPSEL:  rdata[SELW-1:0] = bpsel;
        REG_BPADDR: rdata           = bpaddr_a[bpsel];
        REG_BPCTL:  rdata[2:0]      = bpctl_a[bpsel];
        REG_HIT:    rdata[NBP-1:0]  = hit;
        REG_CYCLE:  rdata[CNTW-1:0] = cycle_q;
        REG_RSVD:   rdata           = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_b16_debug_ctrl.sv
// Scoreboard bench for b16_debug_ctrl: stimulus pushes expected values,
// a negedge monitor pops and compares them.
module tb_b16_debug_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr, data, rdata, cpu_addr;
  logic        r, cpu_r, cpu_fetch, drun, dr, dw, halted;
  logic [1:0]  w, cpu_w;
  logic [2:0]  daddr;

  localparam int S_RDATA = 0, S_DRUN = 1, S_HALT = 2, S_DR = 3, S_DW = 4, S_DADDR = 5;

  typedef struct {
    string       name;
    int          sig;
    logic [15:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  b16_debug_ctrl #(.L(16), .NBP(4), .DBGADDR(11'h7FF), .CNTW(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .data     (data),
    .r        (r),
    .w        (w),
    .rdata    (rdata),
    .cpu_addr (cpu_addr),
    .cpu_r    (cpu_r),
    .cpu_w    (cpu_w),
    .cpu_fetch(cpu_fetch),
    .drun     (drun),
    .dr       (dr),
    .dw       (dw),
    .daddr    (daddr),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] actual(input int sig);
    case (sig)
      S_RDATA: return rdata;
      S_DRUN:  return {15'd0, drun};
      S_HALT:  return {15'd0, halted};
      S_DR:    return {15'd0, dr};
      S_DW:    return {15'd0, dw};
      default: return {13'd0, daddr};
    endcase
  endfunction

  // Monitor: compare every pending expectation on the falling edge
  always @(negedge clk) begin : mon
    exp_t        e;
    logic [15:0] a;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      a = actual(e.sig);
      checks++;
      if (a !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, a, e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_sig(input string name, input int sig, input logic [15:0] exp);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.exp  = exp;
    sbq.push_back(e);
  endtask

  task automatic host_write(input logic [2:0] idx, input logic [15:0] val);
    addr = {11'h7FF, 1'b1, idx, 1'b0};
    data = val;
    w    = 2'b01;
    tick();
    w    = 2'b00;
    data = '0;
  endtask

  task automatic host_read(input string name, input logic [2:0] idx, input logic [15:0] exp);
    addr = {11'h7FF, 1'b1, idx, 1'b0};
    r    = 1'b1;
    expect_sig(name, S_RDATA, exp);
    tick();
    r    = 1'b0;
  endtask

  task automatic cpu_idle();
    cpu_fetch = 1'b0;
    cpu_r     = 1'b0;
    cpu_w     = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; addr = '0; data = '0; r = 1'b0; w = 2'b00;
    cpu_addr = '0; cpu_idle();
    repeat (2) tick();
    expect_sig("drun_in_reset", S_DRUN, 16'd1);
    tick();
    reset = 1'b1;

    // Reset state
    host_read("cycle_start", 3'd6, 16'd0);
    host_read("cycle_next", 3'd6, 16'd1);
    expect_sig("halted_rst", S_HALT, 16'd0);
    host_read("bpaddr_rst", 3'd3, 16'hFFFF);
    host_read("hit_rst", 3'd5, 16'd0);
    host_read("ctrl_rst", 3'd0, 16'h0001);
    host_read("bpctl_rst", 3'd4, 16'd0);
    host_read("step_rst", 3'd1, 16'd0);

    // Fetch breakpoint on channel 2, then resume on the same address
    host_write(3'd2, 16'd2);
    host_write(3'd3, 16'h0100);
    host_write(3'd4, 16'h0001);
    host_read("bp2_addr", 3'd3, 16'h0100);
    cpu_addr = 16'h0100; cpu_fetch = 1'b1; cpu_r = 1'b1;
    expect_sig("drun_match_cycle", S_DRUN, 16'd1);
    tick();
    expect_sig("drun_bp_halt", S_DRUN, 16'd0);
    expect_sig("halted_bp", S_HALT, 16'd1);
    host_read("hit_bp2", 3'd5, 16'h0004);
    host_read("ctrl_bp", 3'd0, 16'h1000);
    host_write(3'd0, 16'h0001);
    expect_sig("resume_drun", S_DRUN, 16'd1);
    tick();
    cpu_idle();
    expect_sig("no_rehit", S_DRUN, 16'd1);
    tick();
    host_write(3'd5, 16'h0004);
    host_read("hit_clr_bit2", 3'd5, 16'd0);

    // Write-mode breakpoint on channel 0
    host_write(3'd2, 16'd0);
    host_write(3'd3, 16'h2000);
    host_write(3'd4, 16'h0005);
    cpu_addr = 16'h2000; cpu_r = 1'b1;
    tick();
    cpu_r = 1'b0; cpu_w = 2'b01;
    expect_sig("wrbp_read_ignored", S_DRUN, 16'd1);
    tick();
    cpu_idle();
    expect_sig("wrbp_halt", S_DRUN, 16'd0);
    host_read("hit_bp0", 3'd5, 16'h0001);
    host_read("ctrl_bp0", 3'd0, 16'h1000);
    host_write(3'd5, 16'h0001);

    // Step three fetches
    cpu_addr = 16'h3000;
    host_write(3'd1, 16'd3);
    host_write(3'd0, 16'h0007);
    host_read("ctrl_step_run", 3'd0, 16'h0003);
    for (int i = 0; i < 3; i++) begin
      cpu_fetch = 1'b1; cpu_r = 1'b1;
      tick();
      cpu_idle();
      if (i < 2) begin
        expect_sig("step_running", S_DRUN, 16'd1);
        host_read("step_count", 3'd1, 16'(2 - i));
      end else begin
        expect_sig("step_halt", S_DRUN, 16'd0);
        host_read("ctrl_step_halt", 3'd0, 16'h2002);
        host_read("step_zero", 3'd1, 16'd0);
      end
    end

    // STEP=0 with step mode halts on the next fetch
    host_write(3'd0, 16'h0003);
    cpu_fetch = 1'b1; cpu_r = 1'b1;
    expect_sig("step0_running", S_DRUN, 16'd1);
    tick();
    cpu_idle();
    expect_sig("step0_halt", S_DRUN, 16'd0);
    host_read("ctrl_step0", 3'd0, 16'h2002);

    // Host CTRL write beats a breakpoint in the same cycle
    host_write(3'd2, 16'd1);
    host_write(3'd3, 16'h0100);
    host_write(3'd4, 16'h0007);
    host_write(3'd0, 16'h0001);
    tick();
    cpu_addr = 16'h0100; cpu_fetch = 1'b1; cpu_r = 1'b1;
    host_write(3'd0, 16'h0001);
    cpu_idle();
    expect_sig("host_wins", S_DRUN, 16'd1);
    host_read("hit_host_wins", 3'd5, 16'd0);
    cpu_fetch = 1'b1; cpu_r = 1'b1;
    tick();
    cpu_idle();
    expect_sig("dual_bp_halt", S_DRUN, 16'd0);
    host_read("hit_dual", 3'd5, 16'h0006);
    host_read("ctrl_dual", 3'd0, 16'h1000);
    host_write(3'd5, 16'h000F);
    host_read("hit_w1c", 3'd5, 16'd0);

    // CPU window pass-through and decode boundaries
    addr = 16'hFFE6; r = 1'b1;
    expect_sig("dr_win", S_DR, 16'd1);
    expect_sig("daddr_win", S_DADDR, 16'd3);
    expect_sig("rdata_win", S_RDATA, 16'd0);
    expect_sig("dw_win_idle", S_DW, 16'd0);
    tick();
    r = 1'b0;
    addr = 16'hFFE2; w = 2'b10;
    expect_sig("dw_win", S_DW, 16'd1);
    expect_sig("daddr_win1", S_DADDR, 16'd1);
    expect_sig("dr_win_idle", S_DR, 16'd0);
    tick();
    w = 2'b00;
    addr = 16'h1234; r = 1'b1;
    expect_sig("dr_outside", S_DR, 16'd0);
    expect_sig("rdata_outside", S_RDATA, 16'd0);
    tick();
    r = 1'b0;
    host_read("rsvd", 3'd7, 16'd0);
    host_write(3'd2, 16'd6);
    host_read("bpsel_wrap", 3'd2, 16'd2);

    // Asynchronous reset while halted
    expect_sig("pre_reset_halted", S_DRUN, 16'd0);
    tick();
    reset = 1'b0;
    expect_sig("async_reset_drun", S_DRUN, 16'd1);
    expect_sig("async_reset_halted", S_HALT, 16'd0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    tick();
    host_read("bpsel_after_reset", 3'd2, 16'd0);
    host_read("bpaddr_after_reset", 3'd3, 16'hFFFF);
    host_read("hit_after_reset", 3'd5, 16'd0);

    repeat (4) tick();
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/b16_debug_ctrl.md
Name: b16_debug_ctrl

Overview:
Parametrised debug controller for the b16 core, the next generation of the single-breakpoint debugger. It decodes a 16-word memory-mapped window and forwards the lower 8 words to the CPU debug port (dr/dw/daddr). The upper 8 words are its own registers: NBP breakpoints with access-type modes, hit mask, instruction step counter, halt reason and cycle counter. It drives the CPU run line and sits between the host/bus master and the cpu debug port.

Parameters:
L, 16, data/address width
NBP, 4, number of breakpoint channels (1..8)
DBGADDR, 11'h7FF, window base, compared against addr[L-1:5]
CNTW, 16, width of step and cycle counters (≤ L)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
addr  in  L  host bus address
data  in  L  host write data
r  in  1  host read strobe
w  in  2  host byte write strobes; any set bit is a full-word write
rdata  out  L  controller register read data, combinational
cpu_addr  in  L  CPU bus address
cpu_r  in  1  CPU read strobe
cpu_w  in  2  CPU write strobes
cpu_fetch  in  1  CPU in instruction-fetch state
drun  out  1  CPU run enable
dr  out  1  CPU debug read
dw  out  1  CPU debug write
daddr  out  3  CPU debug register index, equal to addr[3:1]
halted  out  1  equal to ~drun, for LED or IRQ

Behaviour:
- dsel = (addr[L-1:5]==DBGADDR). cpu_sel = dsel & ~addr[4]. dr = cpu_sel & r. dw = cpu_sel & |w.
- Controller registers, selected by dsel & addr[4], index addr[3:1]:
  - 0 CTRL/STAT. Write: bit0 run, bit1 step mode, bit2 clear reason. Read: {reason[3:0] at [15:12], step mode at 1, drun at 0}.
  - 1 STEP. Count of fetches to execute before halt.
  - 2 BPSEL. Index of the breakpoint addressed by regs 3/4; wraps modulo NBP.
  - 3 BPADDR of the selected breakpoint.
  - 4 BPCTL of the selected breakpoint. Bit0 enable; [2:1] mode: 00 fetch, 01 read, 10 write, 11 any.
  - 5 HIT[NBP-1:0]. Write-1-to-clear.
  - 6 CYCLE. Counts clk while drun; read-only; wraps at 2^CNTW.
  - 7 reserved; reads 0.
- rdata is 0 when no controller register is selected.
- Reset values: drun=1, reason=0, step mode=0, STEP=0, BPSEL=0, all BPADDR={L{1}}, all BPCTL=0, HIT=0, CYCLE=0.
- Match for channel i: en & drun & ~skip & (cpu_addr==BPADDR[i]) & mode_ok.
  - fetch: cpu_fetch & cpu_r.
  - read: cpu_r & ~cpu_fetch.
  - write: |cpu_w.
  - any: any of the above.
- Any match in cycle k: HIT bits set, drun=0 and reason=1 at edge k+1. The CPU is stopped before executing the matched cycle's result.
- Step: while drun & step mode, each cpu_fetch cycle decrements STEP. At the edge where STEP goes 1→0: drun=0, reason=2. STEP=0 with step mode set halts on the next fetch.
- Host write of CTRL with run=0: drun=0 next edge, reason=3.
- Host write of CTRL with run=1: drun=1 next edge, and skip=1 for exactly the first cycle drun is high. This suppresses an immediate re-hit on the resume address.
- Priorities within one cycle: host CTRL write > breakpoint > step. Reason holds its first-cause value until cleared (bit2) or overwritten by a new halt.
- Debug-port accesses (dr/dw) are passed through in any state. Legality while running is the CPU's concern.
- Reset asserted mid-operation: all state returns to reset values asynchronously, and drun rises immediately.

Decomposition:
- Package b16_dbg_pkg holds:
  - register index constants (REG_CTRL..REG_CYCLE);
  - mode encodings (BP_FETCH, BP_READ, BP_WRITE, BP_ANY);
  - halt reason codes (RSN_NONE=0, RSN_BP=1, RSN_STEP=2, RSN_HOST=3).
- Sub-module b16_bp_match: one channel holding BPADDR/BPCTL registers and the comparator, outputting a match bit. Instantiated NBP times in a generate loop.

Test Plan:
- Reset → drun=1, rdata(BPADDR any)=16'hFFFF, HIT=0, CYCLE counting from 0.
- BPSEL=2, BPADDR=16'h0100, BPCTL=3'b001. CPU fetches 16'h0100 → drun=0 next edge, HIT=4'b0100, reason=1. Resume with CTRL=1 while cpu_addr stays 16'h0100 → no re-halt on the first cycle.
- BP0 at 16'h2000 in write mode. CPU reads 16'h2000 → no halt. CPU writes w=2'b01 → halt, HIT=4'b0001.
- STEP=3, CTRL=3'b011 → exactly 3 cpu_fetch pulses pass, then drun=0, reason=2, STEP=0.
- Same cycle: host CTRL run=1 write plus a breakpoint match → drun=1 (host wins), HIT unchanged. Write HIT=4'b1111 → HIT=0.
- Host read at addr 16'hFFE6 (index 3, cpu window) → dr=1, daddr=3, rdata=0. Reset pulsed while halted → drun=1 asynchronously.
